exp_series_sequencer: RTL and testbench

//  Iterative fixed-point e^x engine: sequences Taylor-series terms term_k = term_(k-1)*x/k through
//  one shared multiplier, accumulating N_TERMS terms. Sits between a requester (valid/ready in)
//  and a consumer (valid/ready out); it replaces the unrolled combinational series in synthesizable paths.

---
 rtl/exp_pkg.sv | 28 ++
 rtl/exp_term_mul.sv | 30 +++
 rtl/exp_series_sequencer.sv | 169 ++++++++++++++++
 tb/tb_exp_series_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared definitions for the iterative e^x engine.
//   ONE_FX      : 1.0 in the default Q16.16 format
//   exp_state_e : sequencer states
//   recip_fx    : round(2^frac_w / k), used to build the 1/k constant table
package exp_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned FRAC_W_DEF  = 16;
    localparam int unsigned N_TERMS_DEF = 12;

    localparam logic [DATA_W_DEF-1:0] ONE_FX = DATA_W_DEF'(1) << FRAC_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        MUL_X,
        MUL_R,
        DONE
    } exp_state_e;

    // Rounded fixed-point reciprocal of k; k == 0 has no reciprocal and maps to 0.
    function automatic longint unsigned recip_fx(input int unsigned k, input int unsigned frac_w);
        longint unsigned num;
        if (k == 0) return '0;
        num = 64'(1) << frac_w;
        return (num + 64'(k / 2)) / 64'(k);
    endfunction

endpackage

// File: rtl/exp_term_mul.sv
// Signed fixed-point multiply: (a*b) >>> FRAC_W, truncated to DATA_W.
// Ports:
//   a, b    : signed DATA_W operands
//   prod_c  : truncated, arithmetically shifted product (combinational)
//   ovf_c   : shifted product does not fit in DATA_W signed (combinational)
module exp_term_mul #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] prod_c,
    output logic                     ovf_c
);

    localparam int unsigned P_W = 2 * DATA_W;

    logic signed [P_W-1:0] full;
    logic signed [P_W-1:0] shifted;
    logic        [P_W-DATA_W:0] top_bits;

    assign full     = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign shifted  = full >>> FRAC_W;
    assign prod_c   = shifted[DATA_W-1:0];

    // Fits only if everything above the kept sign bit is a copy of it.
    assign top_bits = shifted[P_W-1:DATA_W-1];
    assign ovf_c    = ~(&top_bits) & (|top_bits);

endmodule

// File: rtl/exp_series_sequencer.sv
// Iterative fixed-point e^x: term_k = term_(k-1) * x / k, summed over N_TERMS
// terms through one time-shared multiplier (x in MUL_X, 1/k in MUL_R).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_ready only while idle
//   in_x                : signed Q(DATA_W-FRAC_W).FRAC_W operand
//   out_valid/out_ready : result handshake, result held until accepted
//   out_y               : e^x, saturated to max positive on overflow
//   out_ovf             : overflow seen anywhere while computing this result
// Build option: define EXP_EARLY_EXIT_EN to finish as soon as a term becomes zero.
module exp_series_sequencer
    import exp_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned FRAC_W  = FRAC_W_DEF,
    parameter int unsigned N_TERMS = N_TERMS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_ovf
);

    localparam int unsigned K_W = $clog2(N_TERMS);
    localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_W;
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    exp_state_e state_q, state_d;

    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] term_q, term_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic        [K_W-1:0]    k_q, k_d;
    logic                     ovf_q, ovf_d;

    logic              in_ready_d;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_y_d;
    logic              out_ovf_d;

    logic signed [DATA_W-1:0] recip_tbl [N_TERMS];
    logic signed [DATA_W-1:0] mul_b;
    logic signed [DATA_W-1:0] prod_c;
    logic                     mul_ovf_c;
    logic signed [DATA_W-1:0] acc_sum;
    logic                     acc_ovf;
    logic                     last;

    // Constant 1/k table; entry 0 is never selected.
    for (genvar i = 0; i < N_TERMS; i++) begin : g_recip
        assign recip_tbl[i] = DATA_W'(recip_fx(i, FRAC_W));
    end

    // Single shared multiplier: second operand is x or 1/k depending on phase.
    assign mul_b = (state_q == MUL_R) ? recip_tbl[k_q] : x_q;

    exp_term_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .a      (term_q),
        .b      (mul_b),
        .prod_c (prod_c),
        .ovf_c  (mul_ovf_c)
    );

    // Accumulator add with signed overflow detection.
    assign acc_sum = acc_q + prod_c;
    assign acc_ovf = (acc_q[DATA_W-1] == prod_c[DATA_W-1]) && (acc_sum[DATA_W-1] != acc_q[DATA_W-1]);

`ifdef EXP_EARLY_EXIT_EN
    // Once a term is zero every later term is zero too.
    assign last = (k_q == K_W'(N_TERMS - 1)) || (prod_c == '0);
`else
    assign last = (k_q == K_W'(N_TERMS - 1));
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        term_d      = term_q;
        acc_d       = acc_q;
        k_d         = k_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_y_d     = out_y;
        out_ovf_d   = out_ovf;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d    = MUL_X;
                    x_d        = in_x;
                    term_d     = ONE;
                    acc_d      = ONE;
                    k_d        = K_W'(1);
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b0;
                    out_y_d    = '0;
                    out_ovf_d  = 1'b0;
                end
            end
            MUL_X: begin
                term_d  = prod_c;
                ovf_d   = ovf_q | mul_ovf_c;
                state_d = MUL_R;
            end
            MUL_R: begin
                term_d = prod_c;
                acc_d  = acc_sum;
                k_d    = k_q + K_W'(1);
                ovf_d  = ovf_q | mul_ovf_c | acc_ovf;
                if (last) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_y_d     = ovf_d ? SAT_MAX : acc_sum;
                    out_ovf_d   = ovf_d;
                end else begin
                    state_d = MUL_X;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            term_q    <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            ovf_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            term_q    <= term_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            ovf_q     <= ovf_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_y     <= out_y_d;
            out_ovf   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_exp_series_sequencer.sv
// Self-checking bench for exp_series_sequencer: directed table, back-pressure,
// mid-operation reset and randomized operands against a series model.
module tb_exp_series_sequencer;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned N_TERMS = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    exp_series_sequencer #(
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .N_TERMS (N_TERMS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        int          tol;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                           input int tol);
        longint d;
        checks++;
        d = longint'($signed(act)) - longint'($signed(exp));
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h +/-%0d", name, act, exp, tol);
        end
    endtask

    // Series model: sum of x^k/k! in Q16.16 with truncating products and 1/k rounded.
    function automatic void ref_exp(input logic [31:0] x, output logic [31:0] y,
                                    output logic ovf, output int lat);
        longint term;
        longint acc;
        longint p;
        longint r;
        int     t32;
        int     steps;
        term  = 65536;
        acc   = 65536;
        ovf   = 1'b0;
        steps = 0;
        for (int k = 1; k < int'(N_TERMS); k++) begin
            p = (term * longint'($signed(x))) >>> 16;
            t32 = int'(p);
            if (longint'(t32) != p) ovf = 1'b1;
            term = longint'(t32);
            r = longint'($rtoi(65536.0 / k + 0.5));
            p = (term * r) >>> 16;
            t32 = int'(p);
            if (longint'(t32) != p) ovf = 1'b1;
            term = longint'(t32);
            acc = acc + term;
            t32 = int'(acc);
            if (longint'(t32) != acc) ovf = 1'b1;
            acc = longint'(t32);
            steps = k;
`ifdef EXP_EARLY_EXIT_EN
            if (term == 0) break;
`endif
        end
        y   = ovf ? 32'h7FFF_FFFF : 32'(acc);
        lat = 2 * steps;
    endfunction

    // One complete transaction; counts edges from accept to out_valid.
    task automatic do_op(input logic [31:0] x, output logic [31:0] y, output logic ovf,
                         output int lat, output int busy_bad);
        int n;
        n        = 0;
        busy_bad = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_x     = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 200) begin
            if (out_y != '0 || out_ovf || in_ready) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        y         = out_y;
        ovf       = out_ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t        vecs [7];
    logic [31:0] y;
    logic [31:0] ry;
    logic [31:0] y0;
    logic        ovf;
    logic        rovf;
    int          lat;
    int          rlat;
    int          busy_bad;
    int          n;
    int          bad;

    initial begin
        vecs[0] = '{"x_zero",  32'h0000_0000, 32'h0001_0000, 0,  1'b0};
        vecs[1] = '{"x_one",   32'h0001_0000, 32'h0002_B7E1, 16, 1'b0};
        vecs[2] = '{"x_mone",  32'hFFFF_0000, 32'h0000_5E2D, 16, 1'b0};
        vecs[3] = '{"x_half",  32'h0000_8000, 32'h0001_A613, 16, 1'b0};
        vecs[4] = '{"x_two",   32'h0002_0000, 32'h0007_639A, 16, 1'b0};
        vecs[5] = '{"x_mtwo",  32'hFFFE_0000, 32'h0000_22A5, 16, 1'b0};
        vecs[6] = '{"x_15",    32'h000F_0000, 32'h7FFF_FFFF, 0,  1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y",     out_y,          32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Directed vectors against known values of e^x.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].x, y, ovf, lat, busy_bad);
            ref_exp(vecs[i].x, ry, rovf, rlat);
            chk_tol({vecs[i].name, "_y"}, y, vecs[i].y, vecs[i].tol);
            chk({vecs[i].name, "_ovf"},  32'(ovf),    32'(vecs[i].ovf));
            chk({vecs[i].name, "_lat"},  32'(lat),    32'(rlat));
            chk({vecs[i].name, "_busy"}, 32'(busy_bad), 32'd0);
        end

        // Back-pressure: result held, busy, and an in_valid pulse is dropped.
        in_x     = 32'h0001_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        y0  = out_y;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                in_valid = 1'b1;
                in_x     = 32'h0002_0000;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_y !== y0 || !out_valid || in_ready) bad++;
        end
        in_valid = 1'b0;
        chk("bp_hold", 32'(bad), 32'd0);
        ref_exp(32'h0001_0000, ry, rovf, rlat);
        chk("bp_y", y0, ry);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) bad++;
        end
        chk("bp_dropped", 32'(bad), 32'd0);

        // Reset in the middle of iteration 5 aborts the operation.
        in_x     = 32'h0001_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_y",     out_y,          32'd0);
        chk("mid_rst_ovf",   32'(out_ovf),   32'd0);
        do_op(32'h0000_0000, y, ovf, lat, busy_bad);
        chk("after_rst_y",   y,         32'h0001_0000);
        chk("after_rst_ovf", 32'(ovf),  32'd0);
`ifdef EXP_EARLY_EXIT_EN
        chk("after_rst_lat", 32'(lat),  32'd2);
`else
        chk("after_rst_lat", 32'(lat),  32'd22);
`endif

        // Randomized operands against the model, bit exact.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x;
            if ((i % 8) == 7) x = $urandom;
            else x = 32'($urandom_range(0, 28 * 65536)) - 32'(16 * 65536);
            do_op(x, y, ovf, lat, busy_bad);
            ref_exp(x, ry, rovf, rlat);
            chk("rand_y",   y,          ry);
            chk("rand_ovf", 32'(ovf),   32'(rovf));
            chk("rand_lat", 32'(lat),   32'(rlat));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
